// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with a stallable memory handshake (mem_req/mem_ready).
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       LT,
    input  logic       LTU,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       illegal_instr
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWrite, StMemWb, StExecR,
        StExecI, StAluWb, StJalr, StJal, StUi, StBranch, StTrap
    } state_e;

    state_e state_q, state_d;
    logic   branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        unique case (op)
            OpStore:         ImmSrc = 3'b001;
            OpBranch:        ImmSrc = 3'b010;
            OpJal:           ImmSrc = 3'b011;
            OpLui, OpAuipc:  ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = ~Zero;
            3'b100:  branch_taken = LT;
            3'b101:  branch_taken = ~LT;
            3'b110:  branch_taken = LTU;
            3'b111:  branch_taken = ~LTU;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        retire        = 1'b0;
        illegal_instr = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // PC <= PC + 4 while the instruction register latches
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                casez (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    7'b0?10111:      state_d = StUi;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = StTrap;
`else
                        retire  = 1'b1;
                        state_d = StFetch;
`endif
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StJalr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = StJal;
            end
            StJal: begin
                // Link value OldPC + 4 computed here; PC takes the target from ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StUi: begin
                RegWrite  = 1'b1;
                ResultSrc = (op == OpLui) ? 2'b11 : 2'b00;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = branch_taken;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
`ifdef ILLEGAL_TRAP_EN
                illegal_instr = 1'b1;
`endif
                state_d = StTrap;
            end
            default: state_d = StFetch;
        endcase

        // Reset kills every strobe immediately, even before the clocked state clears
        if (!rst_n) begin
            mem_req       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            AdrSrc        = 1'b0;
            ResultSrc     = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ALUOp         = 2'b00;
            retire        = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: hand-computed output vectors per cycle.
// Output vector: {mem_req,MemWrite,IRWrite,PCWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,retire,illegal_instr}
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero, LT, LTU, mem_ready;
    logic       mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       retire, illegal_instr;
    logic [18:0] obs;

    int vectors = 0;
    int miscompares = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero), .LT(LT), .LTU(LTU),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .retire(retire),
        .illegal_instr(illegal_instr)
    );

    assign obs = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUOp, ImmSrc, retire, illegal_instr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [18:0] v(input logic mreq, mw, irw, pcw, rw, adr,
                                      input logic [1:0] rs, sa, sb, aop,
                                      input logic [2:0] imm, input logic ret, ill);
        return {mreq, mw, irw, pcw, rw, adr, rs, sa, sb, aop, imm, ret, ill};
    endfunction

    function automatic logic [18:0] fetch_go(input logic [2:0] imm);
        return v(1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [18:0] fetch_wait(input logic [2:0] imm);
        return v(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [18:0] decode(input logic [2:0] imm);
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive mem_ready at the falling edge, check mid-cycle, advance one clock.
    task automatic step(input string tag, input logic rdy, input logic [18:0] exp);
        mem_ready = rdy;
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z, lt, ltu,
                              input logic pcw);
        op = 7'b1100011; funct3 = f3; Zero = z; LT = lt; LTU = ltu;
        step({tag, "_fetch"}, 1, fetch_go(3'b010));
        step({tag, "_decode"}, 1, decode(3'b010));
        step({tag, "_branch"}, 1, v(0, 0, 0, pcw, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1, 0));
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000;
        Zero = 1'b0; LT = 1'b0; LTU = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_outputs", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        op = 7'b0100011;
        #1;
        chk("reset_immsrc_store", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        @(negedge clk);
        @(negedge clk);
        chk("reset_held", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        rst_n = 1'b1;
        op = 7'b0110011;
        step("post_reset_fetch", 0, fetch_wait(3'b000));
        step("fetch_stall", 0, fetch_wait(3'b000));

        // add x3,x1,x2
        step("add_fetch", 1, fetch_go(3'b000));
        step("add_decode", 1, decode(3'b000));
        step("add_execr", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));
        step("add_aluwb", 1, v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // lw with three stalled memory cycles
        op = 7'b0000011;
        step("lw_fetch", 1, fetch_go(3'b000));
        step("lw_decode", 1, decode(3'b000));
        step("lw_memadr", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        for (int i = 0; i < 3; i++)
            step("lw_memread_stall", 0, v(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw_memread_done", 1, v(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw_memwb", 1, v(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        run_branch("beq_z1", 3'b000, 1, 0, 0, 1);
        run_branch("bne_z1", 3'b001, 1, 0, 0, 0);
        run_branch("bgeu_ltu0", 3'b111, 0, 0, 0, 1);
        run_branch("blt_lt1", 3'b100, 0, 1, 0, 1);
        run_branch("bge_lt1", 3'b101, 0, 1, 0, 0);
        run_branch("bltu_ltu1", 3'b110, 0, 0, 1, 1);
        run_branch("f3_010", 3'b010, 1, 1, 1, 0);

        // jalr
        op = 7'b1100111;
        step("jalr_fetch", 1, fetch_go(3'b000));
        step("jalr_decode", 1, decode(3'b000));
        step("jalr_jalr", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        step("jalr_jal", 1, v(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0));
        step("jalr_aluwb", 1, v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        // lui / auipc
        op = 7'b0110111;
        step("lui_fetch", 1, fetch_go(3'b100));
        step("lui_decode", 1, decode(3'b100));
        step("lui_ui", 1, v(0, 0, 0, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 1, 0));
        op = 7'b0010111;
        step("auipc_fetch", 1, fetch_go(3'b100));
        step("auipc_decode", 1, decode(3'b100));
        step("auipc_ui", 1, v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 1, 0));

        // sw completing immediately
        op = 7'b0100011;
        step("sw_fetch", 1, fetch_go(3'b001));
        step("sw_decode", 1, decode(3'b001));
        step("sw_memadr", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0, 0));
        step("sw_memwrite", 1, v(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1, 0));

        // sw stalled, then reset pulsed mid-cycle
        step("sw2_fetch", 1, fetch_go(3'b001));
        step("sw2_decode", 1, decode(3'b001));
        step("sw2_memadr", 0, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0, 0));
        step("sw2_stall", 0, v(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        step("sw2_stall", 0, v(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw2_async_reset", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step("sw2_release", 0, fetch_wait(3'b001));
        step("sw2_first_edge", 0, fetch_wait(3'b001));

        // illegal opcode
        op = 7'b0000000;
        step("ill_fetch", 1, fetch_go(3'b000));
`ifdef ILLEGAL_TRAP_EN
        step("ill_decode", 1, decode(3'b000));
        step("ill_trap", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
        step("ill_trap_hold", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ill_trap_reset", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step("ill_after_reset", 0, fetch_wait(3'b000));
`else
        step("ill_decode_nop", 1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1, 0));
        step("ill_back_fetch", 0, fetch_wait(3'b000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
